// File: rtl/reg_router_pkg.sv
// ============================================================================
// reg_router_pkg : shared types, constants and helpers for reg_bus_router
// Revision 1.0
// ============================================================================
`default_nettype none

package reg_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_TURN   = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_0BAD;
  localparam int          MAX_SELW         = 8;

  // Select field is the top selw bits of an aw-bit byte address.
  function automatic logic [MAX_SELW-1:0] sel_of(input logic [31:0] addr,
                                                 input int          aw,
                                                 input int          selw);
    logic [31:0] shifted;
    shifted = addr >> (aw - selw);
    return MAX_SELW'(shifted & ((32'd1 << selw) - 32'd1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_router_timer.sv
// ============================================================================
// reg_router_timer : saturating access counter with terminal-count flag
// Revision 1.0
// ============================================================================
`default_nettype none

module reg_router_timer #(
  parameter int TO_CYC = 255,
  parameter int CW     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CW-1:0] c_term = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] c_max  = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != c_max)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == c_term);

endmodule

`default_nettype wire

// File: rtl/reg_bus_router.sv
// ============================================================================
// reg_bus_router : one-outstanding register-bus router, master -> NT targets
// Optional access timeout enabled by REG_ROUTER_TIMEOUT_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module reg_bus_router
  import reg_router_pkg::*;
#(
  parameter int          NT       = 4,
  parameter int          AW       = 9,
  parameter int          SELW     = 3,
  parameter int          TO_CYC   = 255,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic               app_clk,
  input  logic               reg_rstn,
  input  logic               reg_cs,
  input  logic               reg_wr,
  input  logic [AW-1:0]      reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic [3:0]         reg_be,
  output logic [31:0]        reg_rdata,
  output logic               reg_ack,
  output logic               reg_err,
  output logic [NT-1:0]      tgt_cs,
  output logic               tgt_wr,
  output logic [AW-SELW-1:0] tgt_addr,
  output logic [31:0]        tgt_wdata,
  output logic [3:0]         tgt_be,
  input  logic [NT*32-1:0]   tgt_rdata,
  input  logic [NT-1:0]      tgt_ack
);

  if (NT < 1 || NT > 8 || NT > (1 << SELW) || TO_CYC < 1 || TO_CYC > 65535) begin : g_cfg_check
    $error("reg_bus_router: illegal parameter combination");
  end

  localparam logic [SELW:0] c_nt_ext = (SELW + 1)'(NT);
  localparam logic [NT-1:0] c_cs_lsb = NT'(1);

  state_e             state_q;
  logic               pend_q;
  logic [SELW-1:0]    sel_q;
  logic [NT-1:0]      tgt_cs_q;
  logic               ack_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic               wr_q;
  logic [AW-SELW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;

  logic               w_sel_ok;
  logic               w_ack_hit;
  logic [NT-1:0]      w_cs_onehot;
  logic [31:0]        w_rdata_sel;

  assign w_sel_ok    = ({1'b0, sel_q} < c_nt_ext);
  assign w_cs_onehot = c_cs_lsb << sel_q;
  // tgt_cs_q is one-hot on the selected channel, so masking rejects stray acks.
  assign w_ack_hit   = |(tgt_ack & tgt_cs_q);

  always_comb begin
    w_rdata_sel = '0;
    for (int i = 0; i < NT; i++) begin
      if (tgt_cs_q[i]) begin
        w_rdata_sel = w_rdata_sel | tgt_rdata[32*i +: 32];
      end
    end
  end

`ifdef REG_ROUTER_TIMEOUT_EN
  logic w_tc;

  reg_router_timer #(
    .TO_CYC (TO_CYC),
    .CW     (16)
  ) u_timer (
    .clk   (app_clk),
    .rst_n (reg_rstn),
    .clr_i (state_q == ST_IDLE),
    .en_i  (state_q == ST_ACCESS),
    .tc_o  (w_tc)
  );
`endif

  always_ff @(posedge app_clk or negedge reg_rstn) begin
    if (!reg_rstn) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      sel_q    <= '0;
      tgt_cs_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // First cycle latches the request, second cycle decodes it.
          if (pend_q) begin
            pend_q <= 1'b0;
            if (w_sel_ok) begin
              tgt_cs_q <= w_cs_onehot;
              state_q  <= ST_ACCESS;
            end else begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= ERR_DATA;
              state_q <= ST_RESP;
            end
          end else if (reg_cs) begin
            pend_q  <= 1'b1;
            sel_q   <= SELW'(sel_of(32'(reg_addr), AW, SELW));
            wr_q    <= reg_wr;
            addr_q  <= reg_addr[AW-SELW-1:0];
            wdata_q <= reg_wdata;
            be_q    <= reg_be;
          end
        end
        ST_ACCESS: begin
          if (w_ack_hit) begin
            rdata_q  <= w_rdata_sel;
            tgt_cs_q <= '0;
            ack_q    <= 1'b1;
            state_q  <= ST_RESP;
          end
`ifdef REG_ROUTER_TIMEOUT_EN
          else if (w_tc) begin
            rdata_q  <= ERR_DATA;
            tgt_cs_q <= '0;
            ack_q    <= 1'b1;
            err_q    <= 1'b1;
            state_q  <= ST_RESP;
          end
`else
          // Without a timer the access only ends on the selected target's ack.
`endif
        end
        ST_RESP: begin
          state_q <= ST_TURN;
        end
        ST_TURN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ack   = ack_q;
  assign reg_err   = err_q;
  assign tgt_cs    = tgt_cs_q;
  assign tgt_wr    = wr_q;
  assign tgt_addr  = addr_q;
  assign tgt_wdata = wdata_q;
  assign tgt_be    = be_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_router.sv
// ============================================================================
// tb_reg_bus_router : directed + randomized bench for reg_bus_router
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reg_bus_router;

  localparam int          NT   = 4;
  localparam int          AW   = 9;
  localparam int          SELW = 3;
  localparam int          TO   = 16;
  localparam int          LW   = AW - SELW;
  localparam logic [31:0] ERRD = 32'hDEAD_0BAD;

  logic               app_clk   = 1'b0;
  logic               reg_rstn  = 1'b0;
  logic               reg_cs    = 1'b0;
  logic               reg_wr    = 1'b0;
  logic [AW-1:0]      reg_addr  = '0;
  logic [31:0]        reg_wdata = '0;
  logic [3:0]         reg_be    = '0;
  logic [31:0]        reg_rdata;
  logic               reg_ack;
  logic               reg_err;
  logic [NT-1:0]      tgt_cs;
  logic               tgt_wr;
  logic [LW-1:0]      tgt_addr;
  logic [31:0]        tgt_wdata;
  logic [3:0]         tgt_be;
  logic [NT*32-1:0]   tgt_rdata = '0;
  logic [NT-1:0]      tgt_ack   = '0;

  int vectors     = 0;
  int miscompares = 0;

  reg_bus_router #(
    .NT       (NT),
    .AW       (AW),
    .SELW     (SELW),
    .TO_CYC   (TO),
    .ERR_DATA (ERRD)
  ) dut (
    .app_clk   (app_clk),
    .reg_rstn  (reg_rstn),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .reg_err   (reg_err),
    .tgt_cs    (tgt_cs),
    .tgt_wr    (tgt_wr),
    .tgt_addr  (tgt_addr),
    .tgt_wdata (tgt_wdata),
    .tgt_be    (tgt_be),
    .tgt_rdata (tgt_rdata),
    .tgt_ack   (tgt_ack)
  );

  always #5 app_clk = ~app_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  // One master transaction with a behavioural target on the far side.
  // dly: idle ACCESS cycles before the target raises its ack.
  task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] be, input int dly, input logic [31:0] td,
                        input bit stray, input int late);
    int            sel;
    bit            derr;
    logic [NT-1:0] ecs;
    logic [LW-1:0] eladdr;
    logic [31:0]   erdata;
    bit            to_fire;
    bit            done;
    int            j;
    int            k;

    sel    = int'(addr) / (1 << LW);
    derr   = (sel >= NT);
    ecs    = derr ? '0 : NT'(1 << sel);
    eladdr = LW'(int'(addr) % (1 << LW));
    erdata = ERRD;

    reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
    tick();
    check("latch_cs", 32'(tgt_cs), 32'd0);
    check("latch_ack", 32'(reg_ack), 32'd0);
    tick();
    if (derr) begin
      check("derr_ack", 32'(reg_ack), 32'd1);
      check("derr_err", 32'(reg_err), 32'd1);
      check("derr_rdata", reg_rdata, ERRD);
      check("derr_cs", 32'(tgt_cs), 32'd0);
    end else begin
      check("tgt_cs", 32'(tgt_cs), 32'(ecs));
      check("tgt_addr", 32'(tgt_addr), 32'(eladdr));
      check("tgt_wr", 32'(tgt_wr), 32'(wr));
      check("tgt_wdata", tgt_wdata, wd);
      check("tgt_be", 32'(tgt_be), 32'(be));
      check("early_ack", 32'(reg_ack), 32'd0);
      reg_addr = AW'($urandom); reg_wdata = $urandom; reg_wr = ~wr; reg_be = ~be;
      j = 0;
      done = 1'b0;
      while (!done) begin
        if (j == dly) begin
          tgt_ack[sel] = 1'b1;
          tgt_rdata[32*sel +: 32] = td;
          tick();
          tgt_ack = '0;
          check("ok_ack", 32'(reg_ack), 32'd1);
          check("ok_err", 32'(reg_err), 32'd0);
          check("ok_rdata", reg_rdata, td);
          check("ok_cs_drop", 32'(tgt_cs), 32'd0);
          check("held_addr", 32'(tgt_addr), 32'(eladdr));
          check("held_wdata", tgt_wdata, wd);
          erdata = td;
          done = 1'b1;
        end else begin
          if (stray) begin
            k = (sel + 1 + int'($urandom_range(NT - 2))) % NT;
            tgt_ack[k] = 1'b1;
            tgt_rdata[32*k +: 32] = $urandom;
          end
`ifdef REG_ROUTER_TIMEOUT_EN
          to_fire = (j == TO - 1);
`else
          to_fire = 1'b0;
`endif
          tick();
          tgt_ack = '0;
          if (to_fire) begin
            check("to_ack", 32'(reg_ack), 32'd1);
            check("to_err", 32'(reg_err), 32'd1);
            check("to_rdata", reg_rdata, ERRD);
            check("to_cs_drop", 32'(tgt_cs), 32'd0);
            done = 1'b1;
          end else begin
            check("wait_ack", 32'(reg_ack), 32'd0);
            check("wait_cs", 32'(tgt_cs), 32'(ecs));
          end
        end
        j++;
      end
    end

    tick();
    check("ack_pulse", 32'(reg_ack), 32'd0);
    check("rdata_hold", reg_rdata, erdata);
    reg_cs = 1'b0;
    for (int n = 0; n < late; n++) begin
      tgt_ack[derr ? 0 : sel] = 1'b1;
      tick();
      tgt_ack = '0;
      check("late_ack", 32'(reg_ack), 32'd0);
      check("late_cs", 32'(tgt_cs), 32'd0);
      check("late_hold", reg_rdata, erdata);
    end
    tick();
  endtask

  initial begin
    reg_rstn = 1'b0;
    tick();
    tick();
    check("rst_cs", 32'(tgt_cs), 32'd0);
    check("rst_ack", 32'(reg_ack), 32'd0);
    check("rst_err", 32'(reg_err), 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_wr", 32'(tgt_wr), 32'd0);
    check("rst_addr", 32'(tgt_addr), 32'd0);
    check("rst_wdata", tgt_wdata, 32'd0);
    check("rst_be", 32'(tgt_be), 32'd0);
    reg_rstn = 1'b1;
    tick();

    do_txn(9'h085, 1'b0, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b0, 2);
    do_txn(9'h004, 1'b1, 32'hA5A5_0F0F, 4'b0011, 0, 32'h0BAD_F00D, 1'b0, 0);
    do_txn(9'h1C0, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 2);
    do_txn(9'h0C8, 1'b0, 32'h0, 4'hF, 4, 32'hCAFE_0003, 1'b1, 0);
    do_txn(9'h07C, 1'b0, 32'h0, 4'hF, TO - 1, 32'h7E57_0001, 1'b0, 0);
`ifdef REG_ROUTER_TIMEOUT_EN
    do_txn(9'h0A0, 1'b0, 32'h0, 4'hF, 1000, 32'h0, 1'b0, 4);
`endif

    // Asynchronous reset in the middle of an access.
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 9'h040; reg_wdata = 32'h0; reg_be = 4'hF;
    tick();
    tick();
    check("mid_cs", 32'(tgt_cs), 32'h2);
    tick();
    reg_rstn = 1'b0;
    #1;
    check("mid_rst_cs", 32'(tgt_cs), 32'd0);
    check("mid_rst_ack", 32'(reg_ack), 32'd0);
    reg_cs = 1'b0;
    tick();
    check("mid_rst_addr", 32'(tgt_addr), 32'd0);
    reg_rstn = 1'b1;
    tick();
    check("post_rst_ack", 32'(reg_ack), 32'd0);
    do_txn(9'h041, 1'b1, 32'h5555_AAAA, 4'b1100, 2, 32'h1111_2222, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      do_txn(AW'($urandom), 1'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(6)), $urandom, 1'($urandom), int'($urandom_range(2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_bus_router.md
Name: reg_bus_router

Overview:
Parametrised register-bus router that fans one master register bus out to NT target register ports.
- Replaces fixed single-target chip-select decode with registered, one-outstanding routing.
- Targets are selected by the upper address bits.
- Adds a response mux, decode-error and timeout handling.
- Sits between the system register bus (app_clk domain) and peripheral register blocks (USB host, UART, I2C, ...).

Parameters:
NT, 4, number of target channels (1..8)
AW, 9, master address width
SELW, 3, select field width = reg_addr[AW-1 -: SELW]; NT <= 2**SELW
TO_CYC, 255, cycles in ACCESS before timeout (1..65535)
ERR_DATA, 32'hDEAD_0BAD, read data returned on decode error or timeout

Ports:
app_clk  in  1  system clock; all logic on rising edge
reg_rstn  in  1  asynchronous active-low reset
reg_cs  in  1  master request; held high until reg_ack seen, dropped the cycle after
reg_wr  in  1  1 = write, 0 = read
reg_addr  in  AW  byte address
reg_wdata  in  32  write data
reg_be  in  4  byte enables
reg_rdata  out  32  read data, valid while reg_ack=1
reg_ack  out  1  one-cycle completion pulse
reg_err  out  1  valid with reg_ack; 1 = decode error or timeout
tgt_cs  out  NT  one-hot target select, registered
tgt_wr  out  1  latched reg_wr
tgt_addr  out  AW-SELW  latched local address reg_addr[AW-SELW-1:0]
tgt_wdata  out  32  latched write data
tgt_be  out  4  latched byte enables
tgt_rdata  in  NT*32  target read data; channel i at [32*i +: 32]
tgt_ack  in  NT  per-target ack

Behaviour:
- Reset (reg_rstn=0, async): state=IDLE. tgt_cs, reg_ack, reg_err and timeout counter = 0. reg_rdata, tgt_wr, tgt_addr, tgt_wdata, tgt_be = 0.
- FSM states: IDLE, ACCESS, RESP, TURN.
- IDLE, reg_cs=1 with sel < NT:
  - Latch wr/addr/wdata/be and sel.
  - Next edge: tgt_cs[sel]=1, state -> ACCESS, counter = 0.
- IDLE, reg_cs=1 with sel >= NT:
  - No tgt_cs asserted; state -> RESP.
  - reg_ack=1, reg_err=1, reg_rdata=ERR_DATA.
- ACCESS:
  - Counter increments each cycle; saturates, no wrap.
  - tgt_ack[sel]=1 sampled: capture tgt_rdata[sel] into reg_rdata (writes also capture it; the master ignores it), tgt_cs -> 0, reg_ack=1, reg_err=0, state -> RESP.
  - tgt_ack on non-selected channels is ignored.
- RESP: reg_ack/reg_err held exactly one cycle, then cleared; state -> TURN.
- TURN: one dead cycle so the master can drop reg_cs; reg_cs is ignored; state -> IDLE.
- Minimum latency: reg_cs sampled at edge 0, target acks immediately -> reg_ack high after edge 2. A decode error acks after edge 1.
- Only one transaction outstanding. Inputs changing during ACCESS have no effect (latched copies are used).
- Late tgt_ack arriving in RESP, TURN or IDLE is ignored.
- reg_rdata holds its last value when reg_ack=0.
- Reset mid-transaction: tgt_cs drops asynchronously, no ack is issued, FSM returns to IDLE.

Optional Feature:
REG_ROUTER_TIMEOUT_EN
- Defined:
  - In ACCESS, when counter == TO_CYC-1 and tgt_ack[sel]=0: tgt_cs -> 0, reg_ack=1, reg_err=1, reg_rdata=ERR_DATA, state -> RESP.
  - If tgt_ack[sel] and the terminal count coincide, the ack wins (reg_err=0, target data returned).
- Not defined:
  - No counter logic is synthesised; ACCESS waits indefinitely for tgt_ack.
  - reg_err asserts only for decode errors.

Decomposition:
- Package reg_router_pkg:
  - FSM state enum (IDLE/ACCESS/RESP/TURN, 2 bits).
  - Default ERR_DATA constant.
  - Function sel_of(addr) extracting the select field.
- One sub-module, reg_router_timer: saturating counter with clear/enable and terminal-count flag. Instantiated only under REG_ROUTER_TIMEOUT_EN.

Test Plan:
- Read to target 2 (reg_addr=9'h085, tgt_rdata ch2=32'h1234_5678, tgt_ack[2] one cycle after tgt_cs[2]) -> tgt_cs=4'b0100, tgt_addr=6'h05, reg_rdata=32'h1234_5678, reg_err=0, single-cycle reg_ack.
- Write to target 0 (addr 9'h004, wdata 32'hA5A5_0F0F, be 4'b0011) -> tgt_wr=1 and tgt_wdata/tgt_be match; reg_ack one cycle after tgt_ack[0]; reg_err=0.
- Decode error (reg_addr=9'h1C0, sel=7 >= NT) -> no tgt_cs; reg_ack after edge 1 with reg_err=1, reg_rdata=32'hDEAD_0BAD.
- Timeout with REG_ROUTER_TIMEOUT_EN, TO_CYC=16, target never acks:
  - tgt_cs drops after 16 ACCESS cycles; reg_ack with reg_err=1, reg_rdata=ERR_DATA.
  - A tgt_ack injected 3 cycles later is ignored.
- Ack on the terminal-count cycle -> reg_err=0, target data returned.
- Stray tgt_ack[1] during access to channel 3 -> ignored.
- reg_rstn pulsed low mid-ACCESS -> tgt_cs=0 immediately, no reg_ack, next request completes normally.
